// File: rtl/stopwatch_core_if.sv
// Button-pulse inputs and time/run outputs of the stopwatch core, grouped for
// connection between the debouncer/display stages and the core.
interface stopwatch_core_if;
    logic       i_btn_run;
    logic       i_btn_clear;
    logic       o_run;
    logic [6:0] o_msec;
    logic [5:0] o_sec;
    logic [5:0] o_min;
    logic [4:0] o_hour;

    modport master (
        output i_btn_run, i_btn_clear,
        input  o_run, o_msec, o_sec, o_min, o_hour
    );

    modport slave (
        input  i_btn_run, i_btn_clear,
        output o_run, o_msec, o_sec, o_min, o_hour
    );
endinterface

// File: rtl/stopwatch_core.sv
// Run/stop/clear stopwatch: a prescaler produces 1/100 s ticks that drive a
// centisecond/second/minute/hour counter chain with same-edge carries.
module stopwatch_core #(
    parameter int TICK_DIV = 1_000_000
) (
    input  logic            clk,
    input  logic            reset,
    stopwatch_core_if.slave bus
);
    localparam int              PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_STOP  = 2'b00,
        ST_RUN   = 2'b01,
        ST_CLEAR = 2'b10
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          run_q;
    logic          tick;
    logic [6:0]    msec_q, msec_d;
    logic [5:0]    sec_q,  sec_d;
    logic [5:0]    min_q,  min_d;
    logic [4:0]    hour_q, hour_d;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d = ST_STOP;
        case (state_q)
            ST_STOP: begin
                if (bus.i_btn_clear)    state_d = ST_CLEAR;
                else if (bus.i_btn_run) state_d = ST_RUN;
                else                    state_d = ST_STOP;
            end
            ST_RUN:   state_d = bus.i_btn_run ? ST_STOP : ST_RUN;
            ST_CLEAR: state_d = ST_STOP;
            default:  state_d = ST_STOP;
        endcase
    end

    // A stop pulse freezes the prescaler, so a tick due on that edge is dropped.
    always_comb begin
        presc_d = presc_q;
        tick    = 1'b0;
        if (state_q == ST_CLEAR) begin
            presc_d = '0;
        end else if (state_q == ST_RUN && state_d == ST_RUN) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                tick    = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    always_comb begin
        msec_d = msec_q;
        sec_d  = sec_q;
        min_d  = min_q;
        hour_d = hour_q;
        if (state_q == ST_CLEAR) begin
            msec_d = '0;
            sec_d  = '0;
            min_d  = '0;
            hour_d = '0;
        end else if (tick) begin
            if (msec_q == 7'd99) begin
                msec_d = '0;
                if (sec_q == 6'd59) begin
                    sec_d = '0;
                    if (min_q == 6'd59) begin
                        min_d  = '0;
                        hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
                    end else begin
                        min_d = min_q + 6'd1;
                    end
                end else begin
                    sec_d = sec_q + 6'd1;
                end
            end else begin
                msec_d = msec_q + 7'd1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_STOP;
            presc_q <= '0;
            run_q   <= 1'b0;
            msec_q  <= '0;
            sec_q   <= '0;
            min_q   <= '0;
            hour_q  <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            run_q   <= (state_d == ST_RUN);
            msec_q  <= msec_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            hour_q  <= hour_d;
        end
    end

    assign bus.o_run  = run_q;
    assign bus.o_msec = msec_q;
    assign bus.o_sec  = sec_q;
    assign bus.o_min  = min_q;
    assign bus.o_hour = hour_q;
endmodule

// File: tb/tb_stopwatch_core.sv
// Self-checking bench for stopwatch_core: a time-in-centiseconds reference model
// checked every cycle, directed boundary scenarios, then randomized button traffic.
module tb_stopwatch_core;
    localparam int TICK_DIV = 4;
    localparam int DAY_CS   = 24 * 60 * 60 * 100;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    stopwatch_core_if bus();

    stopwatch_core #(.TICK_DIV(TICK_DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    bit check_en = 1'b0;

    // Reference model: elapsed time as one centisecond count plus a mode.
    typedef enum {M_STOP, M_RUN, M_CLEAR} mode_e;
    mode_e m_mode  = M_STOP;
    int    m_presc = 0;
    int    m_t     = 0;

    logic [6:0] f_msec;
    logic [5:0] f_sec;
    logic [5:0] f_min;
    logic [4:0] f_hour;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic check_time(input string tag, input int h, input int m, input int s,
                              input int cs, input bit run);
        check({tag, ".hour"}, 32'(bus.o_hour), 32'(h));
        check({tag, ".min"},  32'(bus.o_min),  32'(m));
        check({tag, ".sec"},  32'(bus.o_sec),  32'(s));
        check({tag, ".msec"}, 32'(bus.o_msec), 32'(cs));
        check({tag, ".run"},  32'(bus.o_run),  32'(run));
    endtask

    always @(posedge clk) begin
        if (!reset) begin
            m_mode  = M_STOP;
            m_presc = 0;
            m_t     = 0;
        end else begin
            case (m_mode)
                M_STOP: begin
                    if (bus.i_btn_clear)    m_mode = M_CLEAR;
                    else if (bus.i_btn_run) m_mode = M_RUN;
                end
                M_RUN: begin
                    if (bus.i_btn_run) begin
                        m_mode = M_STOP;
                    end else begin
                        m_presc = m_presc + 1;
                        if (m_presc == TICK_DIV) begin
                            m_presc = 0;
                            m_t     = (m_t + 1) % DAY_CS;
                        end
                    end
                end
                default: begin
                    m_t     = 0;
                    m_presc = 0;
                    m_mode  = M_STOP;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("cyc.run",  32'(bus.o_run),  32'(m_mode == M_RUN));
            check("cyc.msec", 32'(bus.o_msec), 32'(m_t % 100));
            check("cyc.sec",  32'(bus.o_sec),  32'((m_t / 100) % 60));
            check("cyc.min",  32'(bus.o_min),  32'((m_t / 6000) % 60));
            check("cyc.hour", 32'(bus.o_hour), 32'(m_t / 360000));
        end
    end

    // Called at a falling edge; the pulse is sampled on the following rising edge.
    task automatic pulse(input bit run, input bit clr);
        bus.i_btn_run   = run;
        bus.i_btn_clear = clr;
        @(negedge clk);
        bus.i_btn_run   = 1'b0;
        bus.i_btn_clear = 1'b0;
    endtask

    // Must be called while stopped; the forced value is held through one rising edge.
    task automatic preset(input int h, input int m, input int s, input int cs);
        @(posedge clk);
        #1;
        f_hour = 5'(h);
        f_min  = 6'(m);
        f_sec  = 6'(s);
        f_msec = 7'(cs);
        force dut.hour_q = f_hour;
        force dut.min_q  = f_min;
        force dut.sec_q  = f_sec;
        force dut.msec_q = f_msec;
        m_t = ((h * 60 + m) * 60 + s) * 100 + cs;
        @(posedge clk);
        #1;
        release dut.hour_q;
        release dut.min_q;
        release dut.sec_q;
        release dut.msec_q;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int budget;
        bus.i_btn_run   = 1'b0;
        bus.i_btn_clear = 1'b0;
        reset           = 1'b0;
        repeat (3) @(negedge clk);
        check_en = 1'b1;
        reset    = 1'b1;
        repeat (20) @(negedge clk);
        check_time("idle", 0, 0, 0, 0, 1'b0);

        // 400 cycles of RUN give exactly 100 ticks.
        pulse(1'b1, 1'b0);
        repeat (400) @(negedge clk);
        check_time("run400", 0, 0, 1, 0, 1'b1);
        pulse(1'b1, 1'b0);
        repeat (50) @(negedge clk);
        check_time("frozen", 0, 0, 1, 0, 1'b0);

        // Park the prescaler at 2, then resume: first tick two cycles later.
        pulse(1'b1, 1'b0);
        repeat (2) @(negedge clk);
        pulse(1'b1, 1'b0);
        repeat (5) @(negedge clk);
        pulse(1'b1, 1'b0);
        check("partial.c1", 32'(bus.o_msec), 32'd0);
        @(negedge clk);
        check("partial.c2", 32'(bus.o_msec), 32'd0);
        @(negedge clk);
        check("partial.tick", 32'(bus.o_msec), 32'd1);

        budget = 100;
        while (bus.o_msec != 7'd5 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("reach_msec5", 32'(bus.o_msec), 32'd5);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        @(negedge clk);
        check_time("cleared", 0, 0, 0, 0, 1'b0);

        // run+clear in RUN only stops; in STOP it clears.
        pulse(1'b1, 1'b0);
        repeat (30) @(negedge clk);
        pulse(1'b1, 1'b1);
        check_time("both_in_run", 0, 0, 0, 7, 1'b0);
        repeat (5) @(negedge clk);
        pulse(1'b1, 1'b1);
        @(negedge clk);
        check_time("both_in_stop", 0, 0, 0, 0, 1'b0);

        // Full-day wrap and minute carry.
        preset(23, 59, 59, 99);
        pulse(1'b1, 1'b0);
        repeat (3) @(negedge clk);
        check_time("pre_wrap", 23, 59, 59, 99, 1'b1);
        @(negedge clk);
        check_time("day_wrap", 0, 0, 0, 0, 1'b1);
        pulse(1'b1, 1'b0);
        preset(0, 0, 59, 99);
        pulse(1'b1, 1'b0);
        repeat (4) @(negedge clk);
        check_time("min_carry", 0, 1, 0, 0, 1'b1);
        pulse(1'b1, 1'b0);

        // Reset mid-RUN with a run pulse on the same edge.
        pulse(1'b1, 1'b0);
        repeat (10) @(negedge clk);
        reset         = 1'b0;
        bus.i_btn_run = 1'b1;
        @(negedge clk);
        reset         = 1'b1;
        bus.i_btn_run = 1'b0;
        check_time("mid_reset", 0, 0, 0, 0, 1'b0);
        check("mid_reset.presc", 32'(dut.presc_q), 32'd0);

        // Randomized button and reset traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            reset           = ($urandom_range(0, 399) != 0);
            bus.i_btn_run   = ($urandom_range(0, 29) == 0);
            bus.i_btn_clear = ($urandom_range(0, 79) == 0);
        end
        @(negedge clk);
        reset           = 1'b1;
        bus.i_btn_run   = 1'b0;
        bus.i_btn_clear = 1'b0;
        repeat (4) @(negedge clk);
        check_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/stopwatch_core.md
Name: stopwatch_core

Overview:
- Consumes the single-cycle press pulses from the button debouncers. Provides run/stop/clear control and a centisecond/second/minute/hour time counter.
- Outputs feed the FND/display driver stage.
- Single clock domain (100 MHz system clock). Button inputs are already synchronous, debounced, one-cycle pulses.

Parameters:
- TICK_DIV, 1_000_000, clk cycles per 1/100 s tick. Minimum 2. The bench overrides it to 4.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of clk.
- i_btn_run  input  1  run/stop toggle request; one-cycle pulse from the debouncer.
- i_btn_clear  input  1  clear request; one-cycle pulse from the debouncer.
- o_run  output  1  1 while in RUN state.
- o_msec  output  7  centiseconds, 0..99.
- o_sec  output  6  seconds, 0..59.
- o_min  output  6  minutes, 0..59.
- o_hour  output  5  hours, 0..23.

Behaviour:
- Reset (reset==0 at a clk edge):
  - State goes to STOP.
  - Prescaler goes to 0.
  - o_msec, o_sec, o_min, o_hour all go to 0; o_run goes to 0.
  - Reset mid-RUN takes effect at that edge. Button pulses on the same edge are ignored.
- FSM states and transitions (registered; a pulse sampled at edge N changes state at edge N):
  - STOP:
    - i_btn_clear=1 -> CLEAR. Clear has priority if both pulses are high.
    - else i_btn_run=1 -> RUN.
    - else stay in STOP.
  - RUN:
    - i_btn_run=1 -> STOP.
    - i_btn_clear is ignored in RUN. Simultaneous run+clear -> STOP only, with no clear.
  - CLEAR: unconditionally -> STOP after one cycle. Pulses arriving during CLEAR are ignored.
  - Unused encodings -> STOP.
- o_run is a registered decode of state==RUN.
- Prescaler (width $clog2(TICK_DIV)):
  - Increments by 1 per clk only in RUN.
  - At value TICK_DIV-1 it wraps to 0 and generates an internal tick that cycle.
  - Held (not cleared) in STOP, so a resume continues the partial period.
  - Cleared to 0 in CLEAR.
- Time counters:
  - On each tick, o_msec increments.
  - Carry chain:
    - 99 -> 0 carries into o_sec.
    - o_sec 59 -> 0 carries into o_min.
    - o_min 59 -> 0 carries into o_hour.
    - o_hour 23 -> 0 with no further carry (full wrap 23:59:59.99 -> 00:00:00.00).
  - All carries resolve on the same edge as the tick (zero-latency carry, no ripple delay).
  - Counters only change on a tick or in CLEAR. In CLEAR all four go to 0.
- Latency:
  - The first tick after entering RUN occurs TICK_DIV clk cycles after the RUN-entry edge when the prescaler starts at 0.
  - A stop pulse on the edge where the prescaler is at TICK_DIV-1 is a simultaneous event: the state goes to STOP and that tick is not taken; the prescaler holds TICK_DIV-1.
- Outputs are registered and hold their value in STOP indefinitely.

Test Plan (TICK_DIV=4):
- Reset low 3 cycles, then high; no pulses for 20 cycles -> o_run=0, all counters 0, unchanged.
- Run pulse, then 400 clk cycles -> o_run=1, o_msec=0, o_sec=1 (100 ticks). Run pulse again -> o_run=0, counters frozen for 50 cycles.
- From STOP at prescaler=2: run pulse -> first tick after exactly 2 cycles (partial period preserved). Then at o_msec=5, hold STOP and pulse clear -> CLEAR for one cycle, then STOP with all counters 0.
- Run and clear pulsed together in RUN -> STOP with counters unchanged. Pulsed together in STOP -> CLEAR, counters 0, o_run=0.
- Force counters to 23:59:59.99 (hierarchical preset), RUN, one tick -> 00:00:00.00 on that edge. Also check 00:00:59.99 -> 00:01:00.00.
- Reset pulled low mid-RUN with a run pulse on the same edge -> STOP, counters 0, prescaler 0, o_run=0 the next cycle.
